mod_exp_engine: RTL and testbench
=================================

MOD_EXP_ENGINE -- requirements
Module: mod_exp_engine

Interface
REQ-001 SHALL have parameter WIDTH, default 128, operand/modulus width in bits.
REQ-002 SHALL have parameter EXP_WIDTH, default 2*WIDTH, exponent width in bits.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 in_valid  input  1  request present.
REQ-006 in_ready  output  1  engine can accept a request.
REQ-007 base  input  WIDTH  message/ciphertext operand.
REQ-008 exponent  input  EXP_WIDTH  public or private key exponent.
REQ-009 modulus  input  WIDTH  RSA modulus n.
REQ-010 out_valid  output  1  result present.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 result  output  WIDTH  base^exponent mod modulus.
REQ-013 err  output  1  qualifies result; 1 = illegal operands.

Function
REQ-014 Request accepted on rising edge with in_valid && in_ready; base, exponent, modulus registered then; later input changes ignored.
REQ-015 in_ready SHALL be 1 only in IDLE.
REQ-016 States: IDLE, CHECK, SCAN, SQUARE, MULT, DONE.
REQ-017 IDLE -> CHECK on accept; CHECK lasts 1 cycle.
REQ-018 CHECK: modulus==0 or base>=modulus -> DONE with err=1, result=0; exponent==0 -> DONE with result = (modulus==1 ? 0 : 1), err=0; else R=1 and -> SCAN.
REQ-019 SCAN shifts exponent left one bit per cycle while its MSB is 0; on MSB=1 -> SQUARE in the same cycle (no leading-zero cycles beyond z, z = leading-zero count).
REQ-020 For each exponent bit from first 1 down to bit 0: SQUARE computes R=R*R mod modulus; if bit=1, MULT then computes R=R*base mod modulus; then shift to next bit or, after bit 0, -> DONE.
REQ-021 Each modular multiply SHALL take exactly WIDTH+1 cycles (1 load + WIDTH bit-serial iterations, MSB first: P=2P+a_i*B, then subtract modulus up to twice so 0<=P<modulus).
REQ-022 Intermediate accumulator SHALL be WIDTH+2 bits; result never exceeds modulus-1.
REQ-023 Total latency accept -> out_valid = 1 + z + (n + k)*(WIDTH+1) + 1 cycles, n = EXP_WIDTH-z, k = popcount(exponent); illegal/zero-exponent cases: 2 cycles.
REQ-024 DONE: out_valid=1, result and err stable until out_valid && out_ready; then -> IDLE next cycle.
REQ-025 out_ready low SHALL stall indefinitely in DONE with no change to outputs.
REQ-026 in_valid asserted while busy SHALL be ignored (not queued).

Reset
REQ-027 reset asserted SHALL immediately force IDLE, in_ready=1, out_valid=0, result=0, err=0, accumulator and counters cleared.
REQ-028 reset mid-operation SHALL abandon the computation; no out_valid produced for it.
REQ-029 First accept possible on first rising edge after reset deasserts.

Structure
REQ-030 Shared package rsa_pkg SHALL hold the state enumeration and default WIDTH constant.
REQ-031 Single sub-module modmul (bit-serial interleaved modular multiplier, start/done handshake, WIDTH parameter) SHALL be used for both SQUARE and MULT.
REQ-032 No other sub-modules; control FSM and exponent shift register live in mod_exp_engine.

Verification (WIDTH=16, EXP_WIDTH=16)
REQ-033 base=65, exponent=17, modulus=3233 -> result=2790, err=0, latency per REQ-023 (z=11, n=5, k=2 -> 1+11+7*17+1 = 132 cycles).
REQ-034 base=2790, exponent=2753, modulus=3233 -> result=65, err=0 (encrypt/decrypt round trip).
REQ-035 base=4, exponent=0, modulus=497 -> result=1 in 2 cycles; modulus=1, exponent=0 -> result=0.
REQ-036 base=500, modulus=497 -> err=1, result=0; modulus=0 -> err=1.
REQ-037 base=4, exponent=13, modulus=497 with out_ready held low 20 cycles -> result=445 held stable, in_ready=0 throughout, then accepted; new request accepted 1 cycle later.
REQ-038 reset pulsed during MULT of a running request -> out_valid stays 0, in_ready=1 next edge, subsequent 4^13 mod 497 returns 445.

Source files
------------

// File: rtl/rsa_pkg.sv
// ============================================================
// Package : rsa_pkg
// Shared state encoding and default width for the mod-exp slice.
// Revision: 1.0
// ============================================================
`default_nettype none

package rsa_pkg;

  localparam int DEFAULT_WIDTH = 128;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    SCAN   = 3'd2,
    SQUARE = 3'd3,
    MULT   = 3'd4,
    DONE   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/mod_exp_engine_if.sv
// ============================================================
// Interface : mod_exp_engine_if
// Request/response handshake bundle of the modular exponentiator.
// Revision: 1.0
// ============================================================
`default_nettype none

interface mod_exp_engine_if #(
  parameter int WIDTH     = rsa_pkg::DEFAULT_WIDTH,
  parameter int EXP_WIDTH = 2 * WIDTH
);

  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     base;
  logic [EXP_WIDTH-1:0] exponent;
  logic [WIDTH-1:0]     modulus;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH-1:0]     result;
  logic                 err;

  modport master (
    output in_valid, base, exponent, modulus, out_ready,
    input  in_ready, out_valid, result, err
  );

  modport slave (
    input  in_valid, base, exponent, modulus, out_ready,
    output in_ready, out_valid, result, err
  );

endinterface

`default_nettype wire

// File: rtl/mod_exp_engine_modmul.sv
// ============================================================
// Module : modmul
// Bit-serial interleaved modular multiplier (a*b mod m), MSB first.
// Revision: 1.0
// ============================================================
`default_nettype none

module modmul
  import rsa_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  wire logic             clk,
  input  wire logic             reset,
  input  wire logic             start,
  input  wire logic [WIDTH-1:0] a,
  input  wire logic [WIDTH-1:0] b,
  input  wire logic [WIDTH-1:0] m,
  output logic                  busy,
  output logic                  done,
  output logic [WIDTH-1:0]      p
);

  localparam int             c_CNT_W = $clog2(WIDTH + 1);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-1:0]   r_m;
  logic [WIDTH+1:0]   r_p;
  logic [c_CNT_W-1:0] r_cnt;
  logic               r_busy;

  logic [WIDTH+1:0]   w_m_ext;
  logic [WIDTH+1:0]   w_dbl;
  logic [WIDTH+1:0]   w_s1;
  logic [WIDTH+1:0]   w_s2;

  // P < m on entry, so 2P + B < 3m: two conditional subtractions restore P < m.
  always_comb begin
    w_m_ext = {2'b00, r_m};
    w_dbl   = (r_p << 1) + (r_a[WIDTH-1] ? {2'b00, r_b} : '0);
    w_s1    = (w_dbl >= w_m_ext) ? (w_dbl - w_m_ext) : w_dbl;
    w_s2    = (w_s1 >= w_m_ext) ? (w_s1 - w_m_ext) : w_s1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_a    <= '0;
      r_b    <= '0;
      r_m    <= '0;
      r_p    <= '0;
      r_cnt  <= '0;
      r_busy <= 1'b0;
    end else if (!r_busy) begin
      if (start) begin
        r_a    <= a;
        r_b    <= b;
        r_m    <= m;
        r_p    <= '0;
        r_cnt  <= '0;
        r_busy <= 1'b1;
      end
    end else begin
      r_p   <= w_s2;
      r_a   <= r_a << 1;
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == c_LAST) begin
        r_busy <= 1'b0;
      end
    end
  end

  assign busy = r_busy;
  assign done = r_busy && (r_cnt == c_LAST);
  assign p    = w_s2[WIDTH-1:0];

endmodule

`default_nettype wire

// File: rtl/mod_exp_engine.sv
// ============================================================
// Module : mod_exp_engine
// Left-to-right square-and-multiply modular exponentiation.
// Revision: 1.0
// ============================================================
`default_nettype none

module mod_exp_engine
  import rsa_pkg::*;
#(
  parameter int WIDTH     = DEFAULT_WIDTH,
  parameter int EXP_WIDTH = 2 * WIDTH
) (
  input  wire logic         clk,
  input  wire logic         reset,
  mod_exp_engine_if.slave   bus
);

  localparam int                  c_BITS_W = $clog2(EXP_WIDTH + 1);
  localparam logic [c_BITS_W-1:0] c_BITS_INIT = c_BITS_W'(EXP_WIDTH);
  localparam logic [c_BITS_W-1:0] c_BITS_LAST = c_BITS_W'(1);

  state_t                r_state;
  state_t                w_state_next;

  logic [WIDTH-1:0]      r_base;
  logic [WIDTH-1:0]      r_mod;
  logic [EXP_WIDTH-1:0]  r_exp;
  logic [c_BITS_W-1:0]   r_bits;
  logic [WIDTH-1:0]      r_acc;
  logic [WIDTH-1:0]      r_result;
  logic                  r_err;

  logic                  w_in_ready;
  logic                  w_out_valid;
  logic                  w_mm_start;
  logic                  w_mm_busy;
  logic                  w_mm_done;
  logic [WIDTH-1:0]      w_mm_b;
  logic [WIDTH-1:0]      w_mm_p;
  logic                  w_illegal;
  logic                  w_exp_zero;
  logic                  w_last_bit;

  assign w_illegal  = (r_mod == '0) || (r_base >= r_mod);
  assign w_exp_zero = (r_exp == '0);
  assign w_last_bit = (r_bits == c_BITS_LAST);
  assign w_mm_b     = (r_state == MULT) ? r_base : r_acc;

  modmul #(
    .WIDTH (WIDTH)
  ) u_modmul (
    .clk   (clk),
    .reset (reset),
    .start (w_mm_start),
    .a     (r_acc),
    .b     (w_mm_b),
    .m     (r_mod),
    .busy  (w_mm_busy),
    .done  (w_mm_done),
    .p     (w_mm_p)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    w_mm_start   = 1'b0;
    case (r_state)
      IDLE: begin
        w_in_ready = 1'b1;
        if (bus.in_valid) begin
          w_state_next = CHECK;
        end
      end
      CHECK: begin
        if (w_illegal || w_exp_zero) begin
          w_state_next = DONE;
        end else if (r_exp[EXP_WIDTH-1]) begin
          w_state_next = SQUARE;
        end else begin
          w_state_next = SCAN;
        end
      end
      // The bit about to become MSB decides, so SCAN spends exactly z cycles.
      SCAN: begin
        if (r_exp[EXP_WIDTH-2]) begin
          w_state_next = SQUARE;
        end
      end
      SQUARE: begin
        w_mm_start = !w_mm_busy;
        if (w_mm_done) begin
          if (r_exp[EXP_WIDTH-1]) begin
            w_state_next = MULT;
          end else if (w_last_bit) begin
            w_state_next = DONE;
          end
        end
      end
      MULT: begin
        w_mm_start = !w_mm_busy;
        if (w_mm_done) begin
          w_state_next = w_last_bit ? DONE : SQUARE;
        end
      end
      DONE: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) begin
          w_state_next = IDLE;
        end
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_base   <= '0;
      r_mod    <= '0;
      r_exp    <= '0;
      r_bits   <= '0;
      r_acc    <= '0;
      r_result <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.in_valid) begin
            r_base <= bus.base;
            r_exp  <= bus.exponent;
            r_mod  <= bus.modulus;
          end
        end
        CHECK: begin
          r_bits <= c_BITS_INIT;
          if (w_illegal) begin
            r_result <= '0;
            r_err    <= 1'b1;
          end else if (w_exp_zero) begin
            r_result <= (r_mod == WIDTH'(1)) ? '0 : WIDTH'(1);
            r_err    <= 1'b0;
          end else begin
            r_acc <= WIDTH'(1);
            r_err <= 1'b0;
          end
        end
        SCAN: begin
          r_exp  <= r_exp << 1;
          r_bits <= r_bits - 1'b1;
        end
        SQUARE: begin
          if (w_mm_done) begin
            r_acc <= w_mm_p;
            if (!r_exp[EXP_WIDTH-1]) begin
              if (w_last_bit) begin
                r_result <= w_mm_p;
              end else begin
                r_exp  <= r_exp << 1;
                r_bits <= r_bits - 1'b1;
              end
            end
          end
        end
        MULT: begin
          if (w_mm_done) begin
            r_acc <= w_mm_p;
            if (w_last_bit) begin
              r_result <= w_mm_p;
            end else begin
              r_exp  <= r_exp << 1;
              r_bits <= r_bits - 1'b1;
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.result    = r_result;
  assign bus.err       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_mod_exp_engine.sv
// ============================================================
// Module : tb_mod_exp_engine
// Directed vectors for mod_exp_engine at WIDTH=EXP_WIDTH=16.
// Revision: 1.0
// ============================================================
`default_nettype none

module tb_mod_exp_engine;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mod_exp_engine_if #(.WIDTH(16), .EXP_WIDTH(16)) bus ();

  mod_exp_engine #(
    .WIDTH     (16),
    .EXP_WIDTH (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v)
    else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  // Issues one request with out_ready high; lat counts the CHECK cycle as 1.
  task automatic do_req(input logic [15:0] b, input logic [15:0] e, input logic [15:0] m,
                        output logic [15:0] res, output logic er, output int lat);
    int n;
    bus.in_valid = 1'b1;
    bus.base     = b;
    bus.exponent = e;
    bus.modulus  = m;
    n = 0;
    while (!bus.in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.base     = 16'hFFFF;
    bus.exponent = 16'hFFFF;
    bus.modulus  = 16'h0001;
    lat = 1;
    while (!bus.out_valid && lat < 5000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = bus.result;
    er  = bus.err;
    @(posedge clk);
    #1;
  endtask

  logic [15:0] res;
  logic        er;
  int          lat;
  int          saw;

  initial begin
    checks        = 0;
    errors        = 0;
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.base      = '0;
    bus.exponent  = '0;
    bus.modulus   = '0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 1);
    chk("rst_out_valid", 32'(bus.out_valid), 0);
    chk("rst_result", 32'(bus.result), 0);
    chk("rst_err", 32'(bus.err), 0);

    @(negedge clk);
    reset = 1'b0;
    do_req(16'd65, 16'd17, 16'd3233, res, er, lat);
    chk("enc_result", 32'(res), 2790);
    chk("enc_err", 32'(er), 0);
    chk("enc_latency", 32'(lat), 132);
    chk("enc_back_idle", 32'(bus.in_ready), 1);

    do_req(16'd2790, 16'd2753, 16'd3233, res, er, lat);
    chk("dec_result", 32'(res), 65);
    chk("dec_err", 32'(er), 0);
    chk("dec_latency", 32'(lat), 295);

    do_req(16'd4, 16'd0, 16'd497, res, er, lat);
    chk("exp0_result", 32'(res), 1);
    chk("exp0_err", 32'(er), 0);
    chk("exp0_latency", 32'(lat), 2);

    do_req(16'd0, 16'd0, 16'd1, res, er, lat);
    chk("mod1_result", 32'(res), 0);
    chk("mod1_err", 32'(er), 0);

    do_req(16'd500, 16'd3, 16'd497, res, er, lat);
    chk("base_ge_mod_err", 32'(er), 1);
    chk("base_ge_mod_result", 32'(res), 0);
    chk("base_ge_mod_latency", 32'(lat), 2);

    do_req(16'd5, 16'd3, 16'd0, res, er, lat);
    chk("mod0_err", 32'(er), 1);
    chk("mod0_result", 32'(res), 0);

    // Backpressure: result held while out_ready low, busy requests ignored.
    @(negedge clk);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.base      = 16'd4;
    bus.exponent  = 16'd13;
    bus.modulus   = 16'd497;
    @(posedge clk);
    #1;
    bus.base     = 16'd2;
    bus.exponent = 16'd10;
    bus.modulus  = 16'd1000;
    lat = 1;
    while (!bus.out_valid && lat < 5000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("stall_latency", 32'(lat), 133);
    saw = 0;
    for (int i = 0; i < 20; i++) begin
      if (bus.result !== 16'd445 || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
          bus.err !== 1'b0) begin
        saw++;
      end
      @(posedge clk);
      #1;
    end
    chk("stall_hold_violations", 32'(saw), 0);
    chk("stall_result", 32'(bus.result), 445);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("after_ack_out_valid", 32'(bus.out_valid), 0);
    chk("after_ack_in_ready", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    chk("next_accepted", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 5000) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("next_result", 32'(bus.result), 24);
    chk("next_latency", 32'(lat), 116);
    @(posedge clk);
    #1;

    // Reset during the first MULT of 4^13 mod 497 (cycles 31..47).
    bus.in_valid = 1'b1;
    bus.base     = 16'd4;
    bus.exponent = 16'd13;
    bus.modulus  = 16'd497;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (34) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(bus.in_ready), 1);
    chk("midrst_out_valid", 32'(bus.out_valid), 0);
    chk("midrst_result", 32'(bus.result), 0);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("postrst_in_ready", 32'(bus.in_ready), 1);
    saw = 0;
    for (int i = 0; i < 150; i++) begin
      if (bus.out_valid !== 1'b0) saw++;
      @(posedge clk);
      #1;
    end
    chk("postrst_no_valid", 32'(saw), 0);
    do_req(16'd4, 16'd13, 16'd497, res, er, lat);
    chk("postrst_result", 32'(res), 445);
    chk("postrst_latency", 32'(lat), 133);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
